axi_dma_arbiter: RTL and testbench

- Round-robin arbiter that shares one axi_dma request/response port among nclients requesters (e.g. CPU debug port, framebuffer fetch, rasterizer writeback).
- Grant is locked for a whole transaction: from the first request beat, through all write beats, until the response beat with last is accepted.
- Sits directly in front of axi_dma. It does not touch AXI signals.

---
 rtl/types_amba_pkg.sv | 31 +++
 rtl/axi_dma_arbiter_rr_select.sv | 31 +++
 rtl/axi_dma_arbiter.sv | 152 +++++++++++++++
 tb/tb_axi_dma_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_amba_pkg.sv
// Shared axi_dma payload types and arbiter state encoding.
package types_amba_pkg;

  localparam int unsigned DMA_ABITS   = 48;
  localparam int unsigned DMA_BYTES_W = 10;
  localparam int unsigned DMA_STROB_W = 8;
  localparam int unsigned DMA_DATA_W  = 64;

  typedef struct packed {
    logic                   write;
    logic [DMA_BYTES_W-1:0] bytes;
    logic [DMA_ABITS-1:0]   addr;
    logic [DMA_STROB_W-1:0] strob;
    logic [DMA_DATA_W-1:0]  data;
    logic                   last;
  } dma_req_type;

  typedef struct packed {
    logic                  last;
    logic                  fault;
    logic [DMA_ABITS-1:0]  addr;
    logic [DMA_DATA_W-1:0] data;
  } dma_resp_type;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axi_dma_arbiter_rr_select.sv
// Round-robin priority picker: first set request at or above ptr, wrapping at nclients.
module axi_dma_arbiter_rr_select #(
  parameter  int unsigned nclients = 4,
  localparam int unsigned cw       = $clog2(nclients)
) (
  input  logic [nclients-1:0] req_i,
  input  logic [cw-1:0]       ptr_i,
  output logic [cw-1:0]       idx_o,
  output logic                found_o
);

  localparam int unsigned CANDW = cw + 1;

  logic [CANDW-1:0] cand;

  // Walk the requests starting at the pointer; first hit wins
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < nclients; off++) begin
      cand = CANDW'(ptr_i) + CANDW'(off);
      if (cand >= CANDW'(nclients)) cand = cand - CANDW'(nclients);
      if (!found_o && req_i[cand[cw-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[cw-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_dma_arbiter.sv
// Round-robin owner of the shared axi_dma port; grant is held for a whole transaction.
module axi_dma_arbiter
  import types_amba_pkg::*;
#(
  parameter  int unsigned nclients = 4,
  parameter  int unsigned abits    = 48,
  localparam int unsigned cw       = $clog2(nclients)
) (
  input  logic                     i_clk,
  input  logic                     i_nrst,
  input  logic [nclients-1:0]      i_req_valid,
  input  logic [nclients-1:0]      i_req_write,
  input  logic [10*nclients-1:0]   i_req_bytes,
  input  logic [abits*nclients-1:0] i_req_addr,
  input  logic [8*nclients-1:0]    i_req_strob,
  input  logic [64*nclients-1:0]   i_req_data,
  input  logic [nclients-1:0]      i_req_last,
  output logic [nclients-1:0]      o_req_ready,
  output logic [nclients-1:0]      o_resp_valid,
  output logic                     o_resp_last,
  output logic                     o_resp_fault,
  output logic [abits-1:0]         o_resp_addr,
  output logic [63:0]              o_resp_data,
  input  logic [nclients-1:0]      i_resp_ready,
  output logic                     o_dma_req_valid,
  output logic                     o_dma_req_write,
  output logic [9:0]               o_dma_req_bytes,
  output logic [abits-1:0]         o_dma_req_addr,
  output logic [7:0]               o_dma_req_strob,
  output logic [63:0]              o_dma_req_data,
  output logic                     o_dma_req_last,
  input  logic                     i_dma_req_ready,
  input  logic                     i_dma_resp_valid,
  input  logic                     i_dma_resp_last,
  input  logic                     i_dma_resp_fault,
  input  logic [abits-1:0]         i_dma_resp_addr,
  input  logic [63:0]              i_dma_resp_data,
  output logic                     o_dma_resp_ready,
  output logic                     o_grant_valid,
  output logic [cw-1:0]            o_grant_idx
);

  arb_state_e          state_q;
  logic [cw-1:0]       grant_idx_q;
  logic [cw-1:0]       rr_ptr_q;
  logic [cw-1:0]       rr_ptr_d;
  logic                wr_done_q;
  logic [cw-1:0]       pick_idx;
  logic                pick_found;
  logic                owned;
  logic                in_req;
  logic                req_hs;
  logic                req_final;
  logic                rsp_last_hs;
  logic [nclients-1:0] grant_oh;
  dma_req_type         req_sel;
  dma_resp_type        resp_in;

  axi_dma_arbiter_rr_select #(.nclients(nclients)) u_rr_select (
    .req_i   (i_req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // Select the owning client's request slice
  always_comb begin
    req_sel = '0;
    for (int unsigned k = 0; k < nclients; k++) begin
      if (cw'(k) == grant_idx_q) begin
        req_sel.write = i_req_write[k];
        req_sel.bytes = i_req_bytes[10*k +: 10];
        req_sel.addr  = DMA_ABITS'(i_req_addr[abits*k +: abits]);
        req_sel.strob = i_req_strob[8*k +: 8];
        req_sel.data  = i_req_data[64*k +: 64];
        req_sel.last  = i_req_last[k];
      end
    end
  end

  assign resp_in = '{last:  i_dma_resp_last,
                     fault: i_dma_resp_fault,
                     addr:  DMA_ABITS'(i_dma_resp_addr),
                     data:  i_dma_resp_data};

  assign owned    = (state_q != ARB_IDLE);
  assign in_req   = (state_q == ARB_REQ);
  assign grant_oh = nclients'(1) << grant_idx_q;

  // Request path towards the DMA, gated to the owner while in req
  assign o_dma_req_valid = in_req & i_req_valid[grant_idx_q];
  assign o_dma_req_write = req_sel.write;
  assign o_dma_req_bytes = req_sel.bytes;
  assign o_dma_req_addr  = abits'(req_sel.addr);
  assign o_dma_req_strob = req_sel.strob;
  assign o_dma_req_data  = req_sel.data;
  assign o_dma_req_last  = req_sel.last;
  assign o_req_ready     = (in_req & i_dma_req_ready) ? grant_oh : '0;

  // Response path; also live in req so early write responses reach the owner
  assign o_resp_valid     = (owned & i_dma_resp_valid) ? grant_oh : '0;
  assign o_dma_resp_ready = owned & i_resp_ready[grant_idx_q];
  assign o_resp_last      = resp_in.last;
  assign o_resp_fault     = resp_in.fault;
  assign o_resp_addr      = abits'(resp_in.addr);
  assign o_resp_data      = resp_in.data;

  assign o_grant_valid = owned;
  assign o_grant_idx   = grant_idx_q;

  assign req_hs      = o_dma_req_valid & i_dma_req_ready;
  assign req_final   = req_hs & (~req_sel.write | req_sel.last);
  assign rsp_last_hs = owned & i_dma_resp_valid & i_resp_ready[grant_idx_q] & i_dma_resp_last;
  assign rr_ptr_d    = (grant_idx_q == cw'(nclients - 1)) ? '0 : grant_idx_q + cw'(1);

  // Transaction FSM: idle -> req -> resp -> idle, wr_done marks an early final response
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= ARB_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_idx_q <= pick_idx;
            wr_done_q   <= 1'b0;
            state_q     <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (rsp_last_hs) begin
            rr_ptr_q  <= rr_ptr_d;
            wr_done_q <= 1'b1;
          end
          if (req_final) begin
            state_q <= (wr_done_q | rsp_last_hs) ? ARB_IDLE : ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (rsp_last_hs) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_dma_arbiter.sv
// Randomized bench for axi_dma_arbiter: transaction-level model of clients, DMA and round-robin rule.
`timescale 1ns/1ps
module tb_axi_dma_arbiter;

  typedef struct packed {
    logic         write;
    logic [9:0]   bytes;
    logic [47:0]  addr;
    logic [7:0]   strob;
    logic [511:0] data;
  } txn_t;

  typedef struct packed {
    logic        last;
    logic        fault;
    logic [47:0] addr;
    logic [63:0] data;
  } rb_t;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   req_valid, req_write, req_last, resp_ready;
  logic [39:0]  req_bytes;
  logic [191:0] req_addr;
  logic [31:0]  req_strob;
  logic [255:0] req_data;
  logic         dma_req_ready, dma_resp_valid, dma_resp_last, dma_resp_fault;
  logic [47:0]  dma_resp_addr;
  logic [63:0]  dma_resp_data;

  logic [3:0] o4_req_ready, o4_resp_valid;
  logic [2:0] o3_req_ready, o3_resp_valid;
  logic o4_rl, o4_rf, o3_rl, o3_rf;
  logic [47:0] o4_ra, o3_ra, o4_da, o3_da;
  logic [63:0] o4_rd, o3_rd, o4_dd, o3_dd;
  logic o4_dv, o4_dw, o4_dl, o3_dv, o3_dw, o3_dl;
  logic [9:0] o4_db, o3_db;
  logic [7:0] o4_ds, o3_ds;
  logic o4_drr, o3_drr, o4_gv, o3_gv;
  logic [1:0] o4_gi, o3_gi;

  bit sel3 = 1'b0;
  wire [3:0]   c_req_ready  = sel3 ? {1'b0, o3_req_ready}  : o4_req_ready;
  wire [3:0]   c_resp_valid = sel3 ? {1'b0, o3_resp_valid} : o4_resp_valid;
  wire [113:0] c_bcast      = sel3 ? {o3_rl, o3_rf, o3_ra, o3_rd} : {o4_rl, o4_rf, o4_ra, o4_rd};
  wire [131:0] c_payload    = sel3 ? {o3_dw, o3_db, o3_da, o3_ds, o3_dd, o3_dl}
                                   : {o4_dw, o4_db, o4_da, o4_ds, o4_dd, o4_dl};
  wire         c_dv  = sel3 ? o3_dv  : o4_dv;
  wire         c_drr = sel3 ? o3_drr : o4_drr;
  wire         c_gv  = sel3 ? o3_gv  : o4_gv;
  wire [1:0]   c_gi  = sel3 ? o3_gi  : o4_gi;

  axi_dma_arbiter #(.nclients(4), .abits(48)) dut4 (
    .i_clk(clk), .i_nrst(nrst),
    .i_req_valid(req_valid), .i_req_write(req_write), .i_req_bytes(req_bytes),
    .i_req_addr(req_addr), .i_req_strob(req_strob), .i_req_data(req_data), .i_req_last(req_last),
    .o_req_ready(o4_req_ready), .o_resp_valid(o4_resp_valid), .o_resp_last(o4_rl),
    .o_resp_fault(o4_rf), .o_resp_addr(o4_ra), .o_resp_data(o4_rd), .i_resp_ready(resp_ready),
    .o_dma_req_valid(o4_dv), .o_dma_req_write(o4_dw), .o_dma_req_bytes(o4_db),
    .o_dma_req_addr(o4_da), .o_dma_req_strob(o4_ds), .o_dma_req_data(o4_dd), .o_dma_req_last(o4_dl),
    .i_dma_req_ready(dma_req_ready), .i_dma_resp_valid(dma_resp_valid), .i_dma_resp_last(dma_resp_last),
    .i_dma_resp_fault(dma_resp_fault), .i_dma_resp_addr(dma_resp_addr), .i_dma_resp_data(dma_resp_data),
    .o_dma_resp_ready(o4_drr), .o_grant_valid(o4_gv), .o_grant_idx(o4_gi)
  );

  axi_dma_arbiter #(.nclients(3), .abits(48)) dut3 (
    .i_clk(clk), .i_nrst(nrst),
    .i_req_valid(req_valid[2:0]), .i_req_write(req_write[2:0]), .i_req_bytes(req_bytes[29:0]),
    .i_req_addr(req_addr[143:0]), .i_req_strob(req_strob[23:0]), .i_req_data(req_data[191:0]),
    .i_req_last(req_last[2:0]),
    .o_req_ready(o3_req_ready), .o_resp_valid(o3_resp_valid), .o_resp_last(o3_rl),
    .o_resp_fault(o3_rf), .o_resp_addr(o3_ra), .o_resp_data(o3_rd), .i_resp_ready(resp_ready[2:0]),
    .o_dma_req_valid(o3_dv), .o_dma_req_write(o3_dw), .o_dma_req_bytes(o3_db),
    .o_dma_req_addr(o3_da), .o_dma_req_strob(o3_ds), .o_dma_req_data(o3_dd), .o_dma_req_last(o3_dl),
    .i_dma_req_ready(dma_req_ready), .i_dma_resp_valid(dma_resp_valid), .i_dma_resp_last(dma_resp_last),
    .i_dma_resp_fault(dma_resp_fault), .i_dma_resp_addr(dma_resp_addr), .i_dma_resp_data(dma_resp_data),
    .o_dma_resp_ready(o3_drr), .o_grant_valid(o3_gv), .o_grant_idx(o3_gi)
  );

  txn_t cq [4][$];
  rb_t  rq [$];
  int   cbeat [4];
  int   rx [4];
  int   exp_rx [4];
  int   nc = 4;
  bit   m_busy, m_reqd, m_rspd;
  int   m_owner, m_ptr;
  bit   early_mode;
  int   dma_mode, rsp_mode, rsp_block, cyc;
  bit   prev_gv;
  int   glog [$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic int nbeats(input txn_t t);
    return t.write ? int'(t.bytes) / 8 : 1;
  endfunction

  // Spec rule: first requesting client at or after the pointer, modulo nc
  function automatic int pick(input logic [3:0] v);
    for (int off = 0; off < nc; off++)
      if (v[(m_ptr + off) % nc]) return (m_ptr + off) % nc;
    return -1;
  endfunction

  task automatic add_txn(input int k, input bit wr, input int bytes, input logic [47:0] addr);
    txn_t t;
    t.write = wr;
    t.bytes = 10'(bytes);
    t.addr  = addr;
    t.strob = 8'($urandom);
    for (int i = 0; i < 16; i++) t.data[32*i +: 32] = $urandom;
    cq[k].push_back(t);
    exp_rx[k] += wr ? 1 : bytes / 8;
  endtask

  task automatic rand_txn(input int k);
    add_txn(k, 1'($urandom), 8 * $urandom_range(1, 8), {16'($urandom), $urandom} & ~48'h7);
  endtask

  task automatic push_wresp(input txn_t t);
    rb_t b;
    b.last = 1'b1; b.fault = 1'($urandom); b.addr = t.addr; b.data = {$urandom, $urandom};
    rq.push_back(b);
  endtask

  task automatic model_clear();
    m_busy = 0; m_reqd = 0; m_rspd = 0; m_owner = 0; m_ptr = 0;
    rq.delete(); glog.delete(); prev_gv = 0; rsp_block = 0;
    for (int k = 0; k < 4; k++) begin
      cq[k].delete(); cbeat[k] = 0; rx[k] = 0; exp_rx[k] = 0;
    end
  endtask

  // One clock: drive clients and DMA, check DUT outputs against the model, advance the model
  task automatic step();
    logic [3:0] cv, rr, e_rdy, e_rv;
    logic [131:0] e_pl;
    bit drdy, dvalid, e_qv, e_drr, req_hs, rsp_hs, was_busy;
    txn_t t;
    rb_t b;
    int nb;
    @(negedge clk);
    cyc++;
    cv = '0;
    for (int k = 0; k < 4; k++) begin
      req_write[k] = 1'($urandom); req_last[k] = 1'($urandom);
      req_bytes[10*k +: 10] = 10'($urandom); req_addr[48*k +: 48] = {16'($urandom), $urandom};
      req_strob[8*k +: 8] = 8'($urandom); req_data[64*k +: 64] = {$urandom, $urandom};
      if (k < nc && cq[k].size() > 0) begin
        t = cq[k][0]; nb = nbeats(t); cv[k] = 1'b1;
        req_write[k] = t.write; req_bytes[10*k +: 10] = t.bytes; req_addr[48*k +: 48] = t.addr;
        req_strob[8*k +: 8] = t.strob; req_data[64*k +: 64] = t.data[64*cbeat[k] +: 64];
        req_last[k] = (cbeat[k] == nb - 1);
      end
    end
    req_valid = cv;
    drdy = (dma_mode == 0) ? 1'b1 : (dma_mode == 1) ? (cyc % 2 == 0) : ($urandom % 3 != 0);
    for (int k = 0; k < 4; k++) rr[k] = (rsp_mode == 2) ? ($urandom % 4 != 0) : 1'b1;
    if (rsp_block > 0) begin rr = '0; rsp_block--; end
    resp_ready = rr;
    dma_req_ready = drdy;
    dvalid = (rq.size() > 0) && (rsp_mode != 2 || $urandom % 4 != 0);
    b = {2'($urandom), 16'($urandom), $urandom, $urandom, $urandom};
    if (dvalid) b = rq[0];
    dma_resp_valid = dvalid;
    {dma_resp_last, dma_resp_fault, dma_resp_addr, dma_resp_data} = b;
    #1;
    e_qv  = m_busy && !m_reqd && cv[m_owner];
    e_rdy = (m_busy && !m_reqd && drdy) ? 4'(1 << m_owner) : 4'b0;
    e_rv  = (m_busy && dvalid) ? 4'(1 << m_owner) : 4'b0;
    e_drr = m_busy && rr[m_owner];
    n_vec++;
    if (c_gv !== m_busy) begin n_err++; $display("FAIL cyc%0d grant_valid got %b want %b", cyc, c_gv, m_busy); end
    if (m_busy) begin
      n_vec++;
      if (c_gi !== 2'(m_owner)) begin n_err++; $display("FAIL cyc%0d grant_idx got %0d want %0d", cyc, c_gi, m_owner); end
    end
    n_vec++;
    if (c_req_ready !== e_rdy) begin n_err++; $display("FAIL cyc%0d req_ready got %b want %b", cyc, c_req_ready, e_rdy); end
    n_vec++;
    if (c_resp_valid !== e_rv) begin n_err++; $display("FAIL cyc%0d resp_valid got %b want %b", cyc, c_resp_valid, e_rv); end
    n_vec++;
    if (c_drr !== e_drr) begin n_err++; $display("FAIL cyc%0d dma_resp_ready got %b want %b", cyc, c_drr, e_drr); end
    n_vec++;
    if (c_dv !== e_qv) begin n_err++; $display("FAIL cyc%0d dma_req_valid got %b want %b", cyc, c_dv, e_qv); end
    if (e_qv) begin
      t = cq[m_owner][0];
      e_pl = {t.write, t.bytes, t.addr, t.strob, t.data[64*cbeat[m_owner] +: 64], 1'(cbeat[m_owner] == nbeats(t) - 1)};
      n_vec++;
      if (c_payload !== e_pl) begin n_err++; $display("FAIL cyc%0d dma_req_payload got %h want %h", cyc, c_payload, e_pl); end
    end
    if (e_rv != 0) begin
      n_vec++;
      if (c_bcast !== 114'(b)) begin n_err++; $display("FAIL cyc%0d resp_broadcast got %h want %h", cyc, c_bcast, b); end
    end
    if (c_gv && !prev_gv) glog.push_back(int'(c_gi));
    prev_gv = c_gv;
    was_busy = m_busy;
    req_hs = e_qv && drdy;
    rsp_hs = m_busy && dvalid && rr[m_owner];
    if (rsp_hs) begin
      b = rq.pop_front(); rx[m_owner]++;
      if (b.last) m_rspd = 1;
    end
    if (req_hs) begin
      t = cq[m_owner][0]; nb = nbeats(t);
      if (t.write && early_mode && cbeat[m_owner] == 0) push_wresp(t);
      if (cbeat[m_owner] == nb - 1) begin
        if (!t.write) begin
          for (int i = 0; i < int'(t.bytes) / 8; i++) begin
            b.last = (i == int'(t.bytes) / 8 - 1); b.fault = 1'($urandom);
            b.addr = t.addr + 48'(8 * i); b.data = {$urandom, $urandom};
            rq.push_back(b);
          end
        end else if (!early_mode) push_wresp(t);
        void'(cq[m_owner].pop_front());
        cbeat[m_owner] = 0; m_reqd = 1;
      end else cbeat[m_owner]++;
    end
    if (was_busy) begin
      if (m_reqd && m_rspd) begin m_busy = 0; m_ptr = (m_owner + 1) % nc; end
    end else if (cv != 0) begin
      m_owner = pick(cv); m_busy = 1; m_reqd = 0; m_rspd = 0;
    end
  endtask

  function automatic bit all_done();
    bit d = !m_busy && rq.size() == 0;
    for (int k = 0; k < 4; k++) if (cq[k].size() != 0) d = 0;
    return d;
  endfunction

  task automatic drain(input int max);
    int i = 0;
    while (!all_done() && i < max) begin step(); i++; end
    step();
    n_vec++;
    if (!all_done()) begin n_err++; $display("FAIL drain_timeout after %0d cycles busy=%b rq=%0d", i, m_busy, rq.size()); end
    for (int k = 0; k < nc; k++) begin
      n_vec++;
      if (rx[k] != exp_rx[k]) begin n_err++; $display("FAIL resp_beats client%0d got %0d want %0d", k, rx[k], exp_rx[k]); end
    end
  endtask

  task automatic check_glog(input string name, input int exp [$]);
    n_vec++;
    if (glog != exp) begin
      n_err++;
      $display("FAIL %s grant_order got %p want %p", name, glog, exp);
    end
  endtask

  // Asynchronous reset with clients and DMA shouting; all handshake outputs must be quiet
  task automatic do_reset();
    req_valid = 4'hF; dma_req_ready = 1; dma_resp_valid = 1; resp_ready = 4'hF;
    #2 nrst = 1'b0;
    #1;
    n_vec++;
    if ({c_gv, c_dv, c_drr, c_req_ready, c_resp_valid} !== 11'b0)
      begin n_err++; $display("FAIL reset_outputs got gv%b dv%b drr%b rdy%b rv%b want all 0", c_gv, c_dv, c_drr, c_req_ready, c_resp_valid); end
    req_valid = '0; dma_resp_valid = 0; resp_ready = '0; dma_req_ready = 0;
    model_clear();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    step();
  endtask

  task automatic test_single_read();
    add_txn(2, 0, 8, 48'h100);
    drain(50);
    glog.delete();
    add_txn(0, 0, 8, 48'h200);
    add_txn(3, 0, 8, 48'h300);
    drain(50);
    check_glog("after_client2", '{3, 0});
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      add_txn(0, 0, 16, 48'h1000); add_txn(1, 0, 16, 48'h2000); add_txn(3, 0, 16, 48'h3000);
    end
    drain(200);
    check_glog("rr_013", '{0, 1, 3, 0, 1, 3});
  endtask

  task automatic test_write_burst();
    dma_mode = 1;
    add_txn(1, 1, 32, 48'h4000);
    drain(100);
    dma_mode = 0;
  endtask

  task automatic test_read_stall();
    int i = 0;
    add_txn(0, 0, 64, 48'h5000);
    while (rx[0] < 3 && i < 100) begin step(); i++; end
    rsp_block = 3;
    drain(100);
  endtask

  task automatic test_early_resp();
    early_mode = 1; dma_mode = 1;
    add_txn(3, 1, 32, 48'h6000);
    add_txn(2, 1, 8, 48'h6100);
    drain(100);
    early_mode = 0; dma_mode = 0;
  endtask

  task automatic test_random();
    dma_mode = 2; rsp_mode = 2;
    for (int r = 0; r < 4; r++) begin
      early_mode = r[0];
      for (int k = 0; k < nc; k++) repeat ($urandom_range(0, 3)) rand_txn(k);
      drain(3000);
    end
    dma_mode = 0; rsp_mode = 0; early_mode = 0;
  endtask

  task automatic test_reset_mid();
    int i = 0;
    add_txn(2, 0, 64, 48'h7000);
    while (rx[2] < 2 && i < 100) begin step(); i++; end
    do_reset();
    add_txn(1, 0, 8, 48'h7100);
    step();
    step();
    n_vec++;
    if (c_gv !== 1'b1 || c_gi !== 2'd1) begin n_err++; $display("FAIL post_reset_grant got v%b idx%0d want v1 idx1", c_gv, c_gi); end
    drain(50);
  endtask

  task automatic test_wrap3();
    sel3 = 1; nc = 3;
    do_reset();
    add_txn(1, 0, 8, 48'h8000);
    drain(50);
    glog.delete();
    add_txn(0, 0, 8, 48'h8100); add_txn(1, 0, 8, 48'h8200); add_txn(2, 0, 8, 48'h8300);
    drain(100);
    check_glog("wrap3", '{2, 0, 1});
    test_random();
  endtask

  initial begin
    dma_mode = 0; rsp_mode = 0; early_mode = 0; cyc = 0;
    req_valid = '0; req_write = '0; req_last = '0; resp_ready = '0;
    req_bytes = '0; req_addr = '0; req_strob = '0; req_data = '0;
    dma_req_ready = 0; dma_resp_valid = 0; dma_resp_last = 0; dma_resp_fault = 0;
    dma_resp_addr = '0; dma_resp_data = '0;
    model_clear();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_burst();
    test_read_stall();
    test_early_resp();
    test_random();
    test_reset_mid();
    test_wrap3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
